cpc_fifo_host_ctrl: RTL and testbench
=====================================

# cpc_fifo_host_ctrl

CPLD-resident controller that sequences the host side of the CPC↔Pi FIFO link. It decodes Z80 I/O cycles on the CPC expansion bus and produces the handshakes for both SN74HCT40105 pairs: shift-in to the host→slave FIFO, and output-enable/shift-out from the slave→host FIFO. It also provides the FIFO master-reset and a status register. It sits between the edge-connector bus signals and the FIFO control pins.

## Interface
- BASE_ADDR, 12'hFD8, match value for A[15:4]
- SI_CYCLES, 2, maximum host_fifo_si high width in CLK cycles (≥1)
- SO_CYCLES, 2, host_fifo_sob low width in CLK cycles (≥1)
- MR_CYCLES, 4, host_fifo_reset stretch after reset release or soft reset
- WAIT_TIMEOUT, 255, maximum WAIT_B low cycles (used only with WAIT_STATE_EN)

- CLK  in  1  Z80 bus clock (4 MHz); single clock domain, all state on rising edge
- RESET_B  in  1  asynchronous, active-low reset
- A  in  16  address bus; A[3:2] ignored
- IOREQ_B, RD_B, WR_B  in  1 each  Z80 bus strobes, active low
- D  inout  8  data bus; driven only during a status read
- fifo_host_dir  in  1  host→slave FIFO has space
- fifo_host_dor  in  1  slave→host FIFO has data
- host_fifo_si  out  1  shift-in, active high
- host_fifo_sob  out  1  shift-out, active low
- host_fifo_oeb  out  1  slave→host FIFO output enable, active low
- host_fifo_reset  out  1  FIFO master reset, active high
- WAIT_B  out  1  Z80 wait request, active low

## Operation
- Decode: hit = !IOREQ_B && A[15:4]==BASE_ADDR && A[1]==0. A[0]=0 selects DATA (&FD80); A[0]=1 selects STAT/CTRL (&FD81).
- DATA write: if fifo_host_dir=1, pulse SI. Otherwise drop the byte and set sticky `ovf`.
- DATA read: if fifo_host_dor=1, host_fifo_oeb=0 combinationally while the read hit is active, then pulse SOB after RD_B rises. Otherwise oeb stays 1 (bus floats to 0xFF), no SOB, and sticky `unf` is set.
- STAT read: D = {ovf, unf, 4'b0, fifo_host_dir, fifo_host_dor}. D is driven combinationally only while hit && !RD_B && A[0].
- CTRL write: D[7]=1 starts a soft reset (MR pulse, clears ovf/unf). D[6]=1 clears ovf/unf only.
- FSM states and transitions:
  - IDLE → WR_SI on the registered rising edge of a DATA-write hit with dir=1.
  - WR_SI: si=1 for SI_CYCLES, or until WR_B is sampled high, whichever comes first. → WR_HOLD.
  - WR_HOLD: wait for WR_B high, then → IDLE.
  - IDLE → RD_HOLD on a DATA-read hit with dor=1. RD_HOLD waits for RD_B high → RD_SO.
  - RD_SO: sob=0 for SO_CYCLES → IDLE.
  - Any state → MR on a soft reset. MR: reset=1 for MR_CYCLES → IDLE.
- A dropped write or underflow read goes IDLE → WR_HOLD/RD_HOLD with no pulse, so one bus cycle produces at most one event.
- Bus strobes are synchronous to CLK and registered once; no metastability stage.

## Timing
- Reset values: si=0, sob=1, reset=1, WAIT_B=1, ovf=unf=0, FSM=MR, D tristated, oeb=1.
- After RESET_B deasserts: host_fifo_reset stays 1 for MR_CYCLES rising edges, then 0.
- SI rises 1 cycle after the first CLK edge that samples the write hit. It always falls no later than the edge that samples WR_B=1, so data is stable under SI.
- SOB goes low 1 cycle after the edge that samples RD_B=1. oeb is already 1 by then, because it is gated by RD_B.
- A new DATA access during RD_SO or MR is ignored and sets neither flag. The Z80 cannot issue back-to-back I/O faster than 4 cycles, so SO_CYCLES≤2 never collides.
- RESET_B asserted mid-operation: all outputs take their reset values immediately, asynchronously.

## Configuration
- WAIT_STATE_EN defined:
  - A DATA write with dir=0, or a DATA read with dor=0, drives WAIT_B=0 combinationally from the hit.
  - WAIT_B is held low until the condition clears, then the normal flow runs.
  - Or it is held until WAIT_TIMEOUT cycles elapse; the access then completes as overflow/underflow.
  - The timeout counter width is $clog2(WAIT_TIMEOUT+1).
- WAIT_STATE_EN undefined: WAIT_B is constant 1, there is no counter, and access is immediate drop/underflow.

## Test plan
- Reset: hold RESET_B=0 for 3 cycles, then release → reset=1 for exactly 4 cycles, then 0; si=0, sob=1, STAT read=0x00 with dir=dor=0.
- OUT &FD80,0x5A with dir=1 → one si pulse of 2 cycles, falling before WR_B rises; D=0x5A throughout; ovf=0.
- OUT &FD80 with dir=0 → no si; STAT read bit7=1; OUT &FD81,0x40 then STAT read → bit7=0.
- IN &FD80 with dor=1 → oeb=0 only while RD_B=0; sob low for 2 cycles starting 1 cycle after RD_B rises. With dor=0 → oeb stays 1, no sob, STAT bit6=1.
- OUT &FD81,0x80 → reset=1 for 4 cycles, flags cleared; access to &FD90 or &FD84 → no strobe activity (&FD84 aliases &FD80 only via A[3:2]; verify alias behaviour).
- WAIT_STATE_EN: IN &FD80 with dor=0, raise dor after 10 cycles → WAIT_B low 10 cycles, then normal read + sob. Leave dor=0 → WAIT_B released after 255 cycles, unf=1.

Source files
------------

// File: rtl/cpc_fifo_host_ctrl_if.sv
// CPC expansion-bus strobes and the host-side FIFO handshake pins.
// The bus/FIFO side drives through 'master'; the controller attaches as 'slave'.
interface cpc_fifo_host_ctrl_if;
    logic [15:0] A;
    logic        IOREQ_B;
    logic        RD_B;
    logic        WR_B;
    logic        fifo_host_dir;
    logic        fifo_host_dor;
    logic        host_fifo_si;
    logic        host_fifo_sob;
    logic        host_fifo_oeb;
    logic        host_fifo_reset;
    logic        WAIT_B;

    modport master (
        output A, IOREQ_B, RD_B, WR_B, fifo_host_dir, fifo_host_dor,
        input  host_fifo_si, host_fifo_sob, host_fifo_oeb, host_fifo_reset, WAIT_B
    );

    modport slave (
        input  A, IOREQ_B, RD_B, WR_B, fifo_host_dir, fifo_host_dor,
        output host_fifo_si, host_fifo_sob, host_fifo_oeb, host_fifo_reset, WAIT_B
    );
endinterface

// File: rtl/cpc_fifo_host_ctrl.sv
// Host-side sequencer for the CPC<->Pi FIFO link: Z80 I/O decode, SI/SOB/OEB handshakes,
// FIFO master reset and status. Define WAIT_STATE_EN to stretch blocked accesses with WAIT_B.
module cpc_fifo_host_ctrl #(
    parameter logic [11:0] BASE_ADDR = 12'hFD8,
    parameter int          SI_CYCLES = 2,
    parameter int          SO_CYCLES = 2,
    parameter int          MR_CYCLES = 4
`ifdef WAIT_STATE_EN
    ,
    parameter int          WAIT_TIMEOUT = 255
`endif
) (
    input  logic                 CLK,
    input  logic                 RESET_B,
    cpc_fifo_host_ctrl_if.slave  bus,
    inout  wire  [7:0]           D
);
    localparam int CNT_MAX_SW = (SI_CYCLES > SO_CYCLES) ? SI_CYCLES : SO_CYCLES;
    localparam int CNT_MAX    = (CNT_MAX_SW > MR_CYCLES) ? CNT_MAX_SW : MR_CYCLES;
    localparam int CNT_W      = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] SI_LAST = CNT_W'(SI_CYCLES - 1);
    localparam logic [CNT_W-1:0] SO_LAST = CNT_W'(SO_CYCLES - 1);
    localparam logic [CNT_W-1:0] MR_LAST = CNT_W'(MR_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [2:0] {
        S_IDLE, S_WR_SI, S_WR_HOLD, S_RD_HOLD, S_RD_SO, S_MR, S_WAIT
    } state_t;

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             ovf_reg, ovf_next;
    logic             unf_reg, unf_next;
    logic             pend_reg, pend_next;
    logic             dwr_reg, dwr_prev_reg, drd_reg, drd_prev_reg, cwr_reg, cwr_prev_reg;
    logic             wr_b_reg, rd_b_reg;
    logic [1:0]       ctrl_reg;

    logic hit, data_wr_hit, data_rd_hit, ctrl_wr_hit, stat_rd_hit;
    logic dwr_rise, drd_rise, cwr_rise, oe_active, stat_drive;
    logic unused_addr;

    // A[3:2] are deliberately not decoded, so &FD84 etc. alias the base registers.
    assign hit         = !bus.IOREQ_B && (bus.A[15:4] == BASE_ADDR) && !bus.A[1];
    assign data_wr_hit = hit && !bus.A[0] && !bus.WR_B;
    assign data_rd_hit = hit && !bus.A[0] && !bus.RD_B;
    assign ctrl_wr_hit = hit &&  bus.A[0] && !bus.WR_B;
    assign stat_rd_hit = hit &&  bus.A[0] && !bus.RD_B;
    assign unused_addr = ^bus.A[3:2];

    assign dwr_rise = dwr_reg && !dwr_prev_reg;
    assign drd_rise = drd_reg && !drd_prev_reg;
    assign cwr_rise = cwr_reg && !cwr_prev_reg;

    assign stat_drive = RESET_B && stat_rd_hit;
    assign D = stat_drive ? {ovf_reg, unf_reg, 4'b0000, bus.fifo_host_dir, bus.fifo_host_dor} : 8'hzz;

    always_ff @(posedge CLK or negedge RESET_B) begin
        if (!RESET_B) begin
            state_reg    <= S_MR;
            cnt_reg      <= '0;
            ovf_reg      <= 1'b0;
            unf_reg      <= 1'b0;
            pend_reg     <= 1'b0;
            dwr_reg      <= 1'b0;
            dwr_prev_reg <= 1'b0;
            drd_reg      <= 1'b0;
            drd_prev_reg <= 1'b0;
            cwr_reg      <= 1'b0;
            cwr_prev_reg <= 1'b0;
            wr_b_reg     <= 1'b1;
            rd_b_reg     <= 1'b1;
            ctrl_reg     <= 2'b00;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            ovf_reg      <= ovf_next;
            unf_reg      <= unf_next;
            pend_reg     <= pend_next;
            dwr_reg      <= data_wr_hit;
            dwr_prev_reg <= dwr_reg;
            drd_reg      <= data_rd_hit;
            drd_prev_reg <= drd_reg;
            cwr_reg      <= ctrl_wr_hit;
            cwr_prev_reg <= cwr_reg;
            wr_b_reg     <= bus.WR_B;
            rd_b_reg     <= bus.RD_B;
            ctrl_reg     <= D[7:6];
        end
    end

`ifdef WAIT_STATE_EN
    localparam int WAIT_W = $clog2(WAIT_TIMEOUT + 1);
    logic [WAIT_W-1:0] wait_cnt_reg;
    logic              timed_out, stall_cond, wait_req;

    assign timed_out  = (wait_cnt_reg == WAIT_W'(WAIT_TIMEOUT));
    assign stall_cond = (data_wr_hit && !bus.fifo_host_dir) || (data_rd_hit && !bus.fifo_host_dor);
    // Only a fresh access may stall; one still pending after MR/RD_SO is left alone.
    assign wait_req   = stall_cond && !timed_out &&
                        ((state_reg == S_IDLE && !dwr_prev_reg && !drd_prev_reg) || state_reg == S_WAIT);
    assign bus.WAIT_B = !wait_req;

    always_ff @(posedge CLK or negedge RESET_B) begin
        if (!RESET_B) wait_cnt_reg <= '0;
        else          wait_cnt_reg <= wait_req ? wait_cnt_reg + WAIT_W'(1) : '0;
    end
`else
    assign bus.WAIT_B = 1'b1;
`endif

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        ovf_next   = ovf_reg;
        unf_next   = unf_reg;
        pend_next  = pend_reg;
        case (state_reg)
            S_IDLE: begin
                cnt_next  = '0;
                pend_next = 1'b0;
                if (dwr_rise) begin
                    if (bus.fifo_host_dir) begin
                        state_next = S_WR_SI;
                    end else begin
`ifdef WAIT_STATE_EN
                        state_next = S_WAIT;
`else
                        state_next = S_WR_HOLD;
                        ovf_next   = 1'b1;
`endif
                    end
                end else if (drd_rise) begin
                    if (bus.fifo_host_dor) begin
                        state_next = S_RD_HOLD;
                        pend_next  = 1'b1;
                    end else begin
`ifdef WAIT_STATE_EN
                        state_next = S_WAIT;
`else
                        state_next = S_RD_HOLD;
                        unf_next   = 1'b1;
`endif
                    end
                end
            end
            // Raw WR_B so SI drops on the very edge that sees the strobe release.
            S_WR_SI: begin
                if (bus.WR_B || cnt_reg == SI_LAST) state_next = S_WR_HOLD;
                else                                cnt_next   = cnt_reg + CNT_ONE;
            end
            S_WR_HOLD: begin
                if (wr_b_reg) state_next = S_IDLE;
            end
            S_RD_HOLD: begin
                cnt_next = '0;
                if (rd_b_reg) state_next = pend_reg ? S_RD_SO : S_IDLE;
            end
            S_RD_SO: begin
                if (cnt_reg == SO_LAST) state_next = S_IDLE;
                else                    cnt_next   = cnt_reg + CNT_ONE;
            end
            S_MR: begin
                if (cnt_reg == MR_LAST) state_next = S_IDLE;
                else                    cnt_next   = cnt_reg + CNT_ONE;
            end
`ifdef WAIT_STATE_EN
            S_WAIT: begin
                if (dwr_reg) begin
                    if (bus.fifo_host_dir) begin
                        state_next = S_WR_SI;
                    end else if (timed_out) begin
                        state_next = S_WR_HOLD;
                        ovf_next   = 1'b1;
                    end
                end else if (drd_reg) begin
                    if (bus.fifo_host_dor) begin
                        state_next = S_RD_HOLD;
                        pend_next  = 1'b1;
                    end else if (timed_out) begin
                        state_next = S_RD_HOLD;
                        unf_next   = 1'b1;
                    end
                end else begin
                    state_next = S_IDLE;
                end
            end
`endif
            default: state_next = S_IDLE;
        endcase

        if (cwr_rise) begin
            if (ctrl_reg[1]) begin
                state_next = S_MR;
                cnt_next   = '0;
                pend_next  = 1'b0;
                ovf_next   = 1'b0;
                unf_next   = 1'b0;
            end else if (ctrl_reg[0]) begin
                ovf_next = 1'b0;
                unf_next = 1'b0;
            end
        end
    end

    // OEB follows the raw RD_B so the FIFO releases D before SOB fires.
    always_comb begin
        oe_active = 1'b0;
        if (data_rd_hit) begin
            if (state_reg == S_IDLE && !drd_prev_reg && bus.fifo_host_dor) oe_active = 1'b1;
            if (state_reg == S_RD_HOLD && pend_reg)                         oe_active = 1'b1;
`ifdef WAIT_STATE_EN
            if (state_reg == S_WAIT && bus.fifo_host_dor)                   oe_active = 1'b1;
`endif
        end
    end

    assign bus.host_fifo_si    = (state_reg == S_WR_SI);
    assign bus.host_fifo_sob   = (state_reg != S_RD_SO);
    assign bus.host_fifo_reset = (state_reg == S_MR);
    assign bus.host_fifo_oeb   = !oe_active;
endmodule

// File: tb/tb_cpc_fifo_host_ctrl.sv
// Directed bench for cpc_fifo_host_ctrl: Z80 IN/OUT cycles with hand-computed strobe counts.
// Extra WAIT_B scenarios run when WAIT_STATE_EN is defined.
module tb_cpc_fifo_host_ctrl;
    logic       CLK = 1'b0;
    logic       RESET_B;
    wire  [7:0] D;
    logic [7:0] tb_d;
    logic       tb_d_en;

    int pass_cnt  = 0;
    int check_cnt = 0;

    // Per-transaction observations filled in by bus_cycle.
    int   r_si_lo, r_si_hi, r_oeb_lo, r_oeb_hi, r_sob_first, r_sob_cnt, r_rst_cnt, r_wait_lo;
    logic [7:0] r_d;
    int   rst_cnt;

    cpc_fifo_host_ctrl_if bus_if ();
    assign D = tb_d_en ? tb_d : 8'hzz;

    cpc_fifo_host_ctrl dut (
        .CLK     (CLK),
        .RESET_B (RESET_B),
        .bus     (bus_if),
        .D       (D)
    );

    always #5 CLK = ~CLK;

    task automatic check_eq(input string tag, input int got, input int exp);
        check_cnt++;
        if (got == exp) pass_cnt++;
        else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
    endtask

    // One Z80 I/O cycle: strobes low for 4 edges (longer while WAIT_B is low), then 8 idle edges.
    task automatic bus_cycle(input bit is_wr, input logic [15:0] addr, input logic [7:0] wdata);
        int i;
        r_si_lo = 0; r_si_hi = 0; r_oeb_lo = 0; r_oeb_hi = 0;
        r_sob_first = -1; r_sob_cnt = 0; r_rst_cnt = 0; r_wait_lo = 0; r_d = 8'h00;
        @(negedge CLK);
        bus_if.A       = addr;
        bus_if.IOREQ_B = 1'b0;
        if (is_wr) begin
            tb_d        = wdata;
            tb_d_en     = 1'b1;
            bus_if.WR_B = 1'b0;
        end else begin
            bus_if.RD_B = 1'b0;
        end
        i = 0;
        while (i < 4 || (bus_if.WAIT_B == 1'b0 && i < 400)) begin
            @(negedge CLK);
            r_si_lo   += int'(bus_if.host_fifo_si);
            r_oeb_lo  += int'(!bus_if.host_fifo_oeb);
            r_sob_cnt += int'(!bus_if.host_fifo_sob);
            r_rst_cnt += int'(bus_if.host_fifo_reset);
            r_wait_lo += int'(!bus_if.WAIT_B);
            r_d        = D;
            i++;
        end
        if (bus_if.WAIT_B == 1'b0) check_eq("wait_release_bound", int'(bus_if.WAIT_B), 1);
        bus_if.IOREQ_B = 1'b1;
        bus_if.WR_B    = 1'b1;
        bus_if.RD_B    = 1'b1;
        bus_if.A       = 16'h0000;
        tb_d_en        = 1'b0;
        for (int j = 0; j < 8; j++) begin
            @(negedge CLK);
            r_si_hi   += int'(bus_if.host_fifo_si);
            r_oeb_hi  += int'(!bus_if.host_fifo_oeb);
            r_rst_cnt += int'(bus_if.host_fifo_reset);
            if (!bus_if.host_fifo_sob) begin
                if (r_sob_first < 0) r_sob_first = j;
                r_sob_cnt++;
            end
        end
        $display("%s &%04h d=%02h: si=%0d/%0d oeb_lo=%0d/%0d sob=%0d@%0d rst=%0d wait=%0d rd=%02h",
                 is_wr ? "OUT" : "IN ", addr, is_wr ? wdata : r_d, r_si_lo, r_si_hi,
                 r_oeb_lo, r_oeb_hi, r_sob_cnt, r_sob_first, r_rst_cnt, r_wait_lo, r_d);
    endtask

    initial begin
        bus_if.A             = 16'h0000;
        bus_if.IOREQ_B       = 1'b1;
        bus_if.RD_B          = 1'b1;
        bus_if.WR_B          = 1'b1;
        bus_if.fifo_host_dir = 1'b0;
        bus_if.fifo_host_dor = 1'b0;
        tb_d                 = 8'h00;
        tb_d_en              = 1'b0;
        RESET_B              = 1'b1;

        // Asynchronous reset: outputs must settle before any clock edge.
        #2 RESET_B = 1'b0;
        #1;
        check_eq("rst_reset_out", int'(bus_if.host_fifo_reset), 1);
        check_eq("rst_si",        int'(bus_if.host_fifo_si),    0);
        check_eq("rst_sob",       int'(bus_if.host_fifo_sob),   1);
        check_eq("rst_oeb",       int'(bus_if.host_fifo_oeb),   1);
        check_eq("rst_wait",      int'(bus_if.WAIT_B),          1);
        repeat (3) @(negedge CLK);
        RESET_B = 1'b1;
        rst_cnt = 0;
        #1 rst_cnt += int'(bus_if.host_fifo_reset);
        repeat (7) begin
            @(negedge CLK);
            rst_cnt += int'(bus_if.host_fifo_reset);
        end
        check_eq("mr_after_reset", rst_cnt, 4);

        bus_cycle(1'b0, 16'hFD81, 8'h00);
        check_eq("stat_after_reset", int'(r_d), 8'h00);

        // Accepted write: 2-cycle SI entirely inside the WR_B low window.
        bus_if.fifo_host_dir = 1'b1;
        bus_cycle(1'b1, 16'hFD80, 8'h5A);
        check_eq("wr_si_width", r_si_lo, 2);
        check_eq("wr_si_after", r_si_hi, 0);
        bus_cycle(1'b0, 16'hFD81, 8'h00);
        check_eq("stat_dir_only", int'(r_d), 8'h02);

        // Overflow write, then flag clear through CTRL bit 6.
        bus_if.fifo_host_dir = 1'b0;
        bus_cycle(1'b1, 16'hFD80, 8'hA5);
        check_eq("ovf_no_si", r_si_lo + r_si_hi, 0);
        bus_cycle(1'b0, 16'hFD81, 8'h00);
        check_eq("stat_ovf", int'(r_d), 8'h80);
        bus_cycle(1'b1, 16'hFD81, 8'h40);
        check_eq("clr_no_mr", r_rst_cnt, 0);
        bus_cycle(1'b0, 16'hFD81, 8'h00);
        check_eq("stat_cleared", int'(r_d), 8'h00);

        // Valid read: OEB only under RD_B, SOB 2 cycles starting 1 cycle after release.
        bus_if.fifo_host_dor = 1'b1;
        bus_cycle(1'b0, 16'hFD80, 8'h00);
        check_eq("rd_oeb_during", r_oeb_lo, 4);
        check_eq("rd_oeb_after",  r_oeb_hi, 0);
        check_eq("rd_sob_start",  r_sob_first, 1);
        check_eq("rd_sob_width",  r_sob_cnt, 2);

        // Underflow read.
        bus_if.fifo_host_dor = 1'b0;
        bus_cycle(1'b0, 16'hFD80, 8'h00);
        check_eq("unf_oeb", r_oeb_lo + r_oeb_hi, 0);
        check_eq("unf_sob", r_sob_cnt, 0);
`ifndef WAIT_STATE_EN
        check_eq("unf_no_wait", r_wait_lo, 0);
`endif
        bus_cycle(1'b0, 16'hFD81, 8'h00);
        check_eq("stat_unf", int'(r_d), 8'h40);

        // Both flags set, then soft reset clears them and pulses MR for 4 cycles.
        bus_cycle(1'b1, 16'hFD80, 8'h11);
        bus_cycle(1'b0, 16'hFD81, 8'h00);
        check_eq("stat_both", int'(r_d), 8'hC0);
        bus_cycle(1'b1, 16'hFD81, 8'h80);
        check_eq("soft_mr_width", r_rst_cnt, 4);
        check_eq("soft_mr_no_si", r_si_lo + r_si_hi, 0);
        bus_cycle(1'b0, 16'hFD81, 8'h00);
        check_eq("stat_after_soft", int'(r_d), 8'h00);

        // Address decode: A[3:2] alias, A[11:4] and A[1] must match.
        bus_if.fifo_host_dir = 1'b1;
        bus_cycle(1'b1, 16'hFD84, 8'h33);
        check_eq("alias_fd84_si", r_si_lo, 2);
        bus_cycle(1'b1, 16'hFD90, 8'h33);
        check_eq("miss_fd90_si", r_si_lo + r_si_hi, 0);
        bus_cycle(1'b1, 16'hFD82, 8'h33);
        check_eq("miss_fd82_si", r_si_lo + r_si_hi, 0);
        bus_if.fifo_host_dor = 1'b1;
        bus_cycle(1'b0, 16'hFD90, 8'h00);
        check_eq("miss_fd90_oeb", r_oeb_lo, 0);
        check_eq("miss_fd90_sob", r_sob_cnt, 0);
        bus_if.fifo_host_dir = 1'b0;
        bus_if.fifo_host_dor = 1'b0;

`ifdef WAIT_STATE_EN
        // dor rises 10 cycles into the access: stall, then a normal read with SOB.
        fork
            bus_cycle(1'b0, 16'hFD80, 8'h00);
            begin
                repeat (11) @(negedge CLK);
                #1 bus_if.fifo_host_dor = 1'b1;
            end
        join
        check_eq("wait_dor_len",   r_wait_lo, 10);
        check_eq("wait_dor_sob",   r_sob_cnt, 2);
        check_eq("wait_dor_oeb",   r_oeb_lo, 1);
        bus_if.fifo_host_dor = 1'b0;
        bus_cycle(1'b0, 16'hFD81, 8'h00);
        check_eq("wait_dor_stat",  int'(r_d), 8'h00);

        // dor never rises: WAIT_B spans 255 rising edges (seen at 254 falling edges), then underflow.
        bus_cycle(1'b0, 16'hFD80, 8'h00);
        check_eq("wait_tmo_len",   r_wait_lo, 254);
        check_eq("wait_tmo_sob",   r_sob_cnt, 0);
        bus_cycle(1'b0, 16'hFD81, 8'h00);
        check_eq("wait_tmo_stat",  int'(r_d), 8'h40);
`endif

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end
endmodule
